sal_bank_timer: RTL and testbench
=================================

# sal_bank_timer

Per-bank DDR2 timing tracker that consumes the timing parameters published on TIMING_IF. It sits beside each bank controller FSM and watches the commands that FSM issues. It keeps one down-counter per bank-local constraint (tRCD, tRAS, tRC, tRP, tRTP, tWTP, tRFC). From those counters it gives the FSM registered "command allowed" flags for ACT, RD/WR and PRE.

## Interface
- CNT_W, default 8: width of every internal counter; timing fields are used as CNT_W-bit unsigned values.
- clk  input  1  controller clock.
- rst_n  input  1  reset; asynchronous, active-low.
- timing_if  TIMING_IF.MON  -  consumed fields: t_rcd_m1, t_ras_m1, t_rc_m1, t_rp_m1, t_rtp_m1, t_wtp_m1, t_rfc_m1 (all CNT_W).
- act_i  input  1  ACT issued to this bank this cycle.
- rd_i  input  1  RD issued this cycle.
- wr_i  input  1  WR issued this cycle.
- pre_i  input  1  PRE issued this cycle.
- ref_i  input  1  REF issued this cycle.
- act_ok_o  output  1  ACT legal this cycle.
- rdwr_ok_o  output  1  RD/WR legal this cycle.
- pre_ok_o  output  1  PRE legal this cycle.
- cmd_err_o  output  1  one-cycle pulse reporting a command violation (see Configuration).

## Operation
- Seven counters: cnt_rcd, cnt_ras, cnt_rc, cnt_rp, cnt_rtp, cnt_wtp, cnt_rfc.
- Each counter has a met flag: met_x = (cnt_x == 0).
- Counter loads, on the clock edge ending the command cycle:
  - act_i loads cnt_rcd ← t_rcd_m1, cnt_ras ← t_ras_m1 and cnt_rc ← t_rc_m1.
  - rd_i loads cnt_rtp ← t_rtp_m1.
  - wr_i loads cnt_wtp ← t_wtp_m1.
  - pre_i loads cnt_rp ← t_rp_m1.
  - ref_i loads cnt_rfc ← t_rfc_m1.
- Any counter that is not loaded and is non-zero decrements by 1 each cycle. It saturates at 0; no wrap.
- A reload while a counter is running overwrites the current value (restart), e.g. back-to-back RDs restart tRTP.
- Output flags:
  - act_ok_o = met_rc & met_rp & met_rfc.
  - rdwr_ok_o = met_rcd.
  - pre_ok_o = met_ras & met_rtp & met_wtp.
- All three flags decode counter registers only. They never depend on this cycle's command inputs.
- Timing fields are sampled only at load. Changing a field mid-countdown affects only later loads.
- Simultaneous commands (more than one of act/rd/wr/pre/ref high):
  - every asserted load is performed;
  - cmd_err_o fires if checking is enabled.
- A command asserted while its ok flag is low still performs its load; cmd_err_o fires if checking is enabled.

## Timing
- Command at cycle N with parameter T (field = T−1): the related flag is low from N+1 through N+T−1 and high at N+T.
- T=1 (field 0): the flag stays high; the counter loads 0.
- Loading 0 on a command is legal and never raises the flag-low window.
- cmd_err_o is registered. A violation sampled at cycle N pulses cmd_err_o high for exactly cycle N+1.
- Reset values (rst_n low, asynchronous, any time including mid-countdown):
  - all counters 0;
  - act_ok_o = 1, rdwr_ok_o = 1, pre_ok_o = 1;
  - cmd_err_o = 0.
- No state survives reset.
- Command inputs are ignored while rst_n is low.

## Configuration
- SAL_BANK_TIMER_CHECK_EN defined: the violation checker is compiled in. cmd_err_o pulses for either of:
  - more than one command input high in a cycle;
  - a command whose ok flag is low in that cycle: act_i & !act_ok_o, (rd_i|wr_i) & !rdwr_ok_o, pre_i & !pre_ok_o, or ref_i & !act_ok_o.
- SAL_BANK_TIMER_CHECK_EN undefined: the checker logic is absent and cmd_err_o is tied to 0. Counter and flag behaviour is identical in both builds.

## Test plan
- Reset, then idle: all ok flags 1 and cmd_err_o 0; assert rst_n low mid-countdown → all flags return to 1 immediately, no clock needed.
- t_rcd_m1=3, ACT at cycle 10 → rdwr_ok_o low cycles 11–13, high at 14. With t_ras_m1=7 and t_rc_m1=10: pre_ok_o high at 18, act_ok_o high at 21.
- t_rtp_m1=2 and t_wtp_m1=5; RD at cycle 20 then WR at cycle 22 → pre_ok_o low 21–27, high at 28. RD at 20 and RD at 21 → pre_ok_o high at 24.
- t_rp_m1=2, t_rfc_m1=15; PRE at cycle 5 then REF at cycle 8 → act_ok_o low 6–7, high at 8? No: REF at 8 keeps act_ok_o low 9–23, high at 24. Also change t_rfc_m1 to 3 at cycle 12 → no effect on the running countdown.
- Checker build: ACT at cycle 10 with t_rcd_m1=3, then RD at cycle 12 → cmd_err_o high only at cycle 13. ACT and RD in the same cycle → cmd_err_o pulse the next cycle.
- Non-checker build: repeat the previous scenario → cmd_err_o stays 0 and flag timing is identical to the checker build.

Source files
------------

// File: rtl/sal_bank_timer_if.sv
// rtl/sal_bank_timer_if.sv - TIMING_IF: DDR2 timing parameters (each field is the cycle count minus one)
interface TIMING_IF #(
    parameter int CNT_W = 8
);
    logic [CNT_W-1:0] t_rcd_m1;
    logic [CNT_W-1:0] t_ras_m1;
    logic [CNT_W-1:0] t_rc_m1;
    logic [CNT_W-1:0] t_rp_m1;
    logic [CNT_W-1:0] t_rtp_m1;
    logic [CNT_W-1:0] t_wtp_m1;
    logic [CNT_W-1:0] t_rfc_m1;

    modport MON (
        input t_rcd_m1, t_ras_m1, t_rc_m1, t_rp_m1, t_rtp_m1, t_wtp_m1, t_rfc_m1
    );

    modport SRC (
        output t_rcd_m1, t_ras_m1, t_rc_m1, t_rp_m1, t_rtp_m1, t_wtp_m1, t_rfc_m1
    );
endinterface

// File: rtl/sal_bank_timer.sv
// rtl/sal_bank_timer.sv - per-bank DDR2 timing tracker; SAL_BANK_TIMER_CHECK_EN compiles in the violation checker
module sal_bank_timer #(
    parameter int CNT_W = 8
) (
    input  logic   clk,
    input  logic   rst_n,
    TIMING_IF.MON  timing_if,
    input  logic   act_i,
    input  logic   rd_i,
    input  logic   wr_i,
    input  logic   pre_i,
    input  logic   ref_i,
    output logic   act_ok_o,
    output logic   rdwr_ok_o,
    output logic   pre_ok_o,
    output logic   cmd_err_o
);
    localparam int NCNT = 7;
    localparam int RCD = 0, RAS = 1, RC = 2, RP = 3, RTP = 4, WTP = 5, RFC = 6;
    localparam logic [CNT_W-1:0] C_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] C_ZERO = '0;

    logic [CNT_W-1:0] r_cnt    [NCNT];
    logic [CNT_W-1:0] w_ld_val [NCNT];
    logic [NCNT-1:0]  w_ld;
    logic [NCNT-1:0]  w_met;

    always_comb begin
        w_ld           = '0;
        w_ld[RCD]      = act_i;
        w_ld[RAS]      = act_i;
        w_ld[RC]       = act_i;
        w_ld[RP]       = pre_i;
        w_ld[RTP]      = rd_i;
        w_ld[WTP]      = wr_i;
        w_ld[RFC]      = ref_i;
        w_ld_val[RCD]  = timing_if.t_rcd_m1;
        w_ld_val[RAS]  = timing_if.t_ras_m1;
        w_ld_val[RC]   = timing_if.t_rc_m1;
        w_ld_val[RP]   = timing_if.t_rp_m1;
        w_ld_val[RTP]  = timing_if.t_rtp_m1;
        w_ld_val[WTP]  = timing_if.t_wtp_m1;
        w_ld_val[RFC]  = timing_if.t_rfc_m1;
    end

    // A load always wins over the decrement, so a repeated command restarts its window.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NCNT; i++) begin
                r_cnt[i] <= C_ZERO;
            end
        end else begin
            for (int i = 0; i < NCNT; i++) begin
                if (w_ld[i]) begin
                    r_cnt[i] <= w_ld_val[i];
                end else if (r_cnt[i] != C_ZERO) begin
                    r_cnt[i] <= r_cnt[i] - C_ONE;
                end
            end
        end
    end

    always_comb begin
        w_met = '0;
        for (int i = 0; i < NCNT; i++) begin
            w_met[i] = (r_cnt[i] == C_ZERO);
        end
    end

    assign act_ok_o  = w_met[RC] & w_met[RP] & w_met[RFC];
    assign rdwr_ok_o = w_met[RCD];
    assign pre_ok_o  = w_met[RAS] & w_met[RTP] & w_met[WTP];

`ifdef SAL_BANK_TIMER_CHECK_EN
    logic [4:0] w_cmds;
    logic       w_multi;
    logic       w_early;
    logic       r_cmd_err;

    assign w_cmds  = {act_i, rd_i, wr_i, pre_i, ref_i};
    assign w_multi = |(w_cmds & (w_cmds - 5'd1));
    assign w_early = (act_i & ~act_ok_o) | ((rd_i | wr_i) & ~rdwr_ok_o)
                   | (pre_i & ~pre_ok_o) | (ref_i & ~act_ok_o);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cmd_err <= 1'b0;
        end else begin
            r_cmd_err <= w_multi | w_early;
        end
    end

    assign cmd_err_o = r_cmd_err;
`else
    assign cmd_err_o = 1'b0;
`endif
endmodule

// File: tb/tb_sal_bank_timer.sv
// tb/tb_sal_bank_timer.sv - directed bench for sal_bank_timer with hand-computed flag windows
module tb_sal_bank_timer;
`ifdef SAL_BANK_TIMER_CHECK_EN
    localparam logic CHK = 1'b1;
`else
    localparam logic CHK = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic act_i = 1'b0, rd_i = 1'b0, wr_i = 1'b0, pre_i = 1'b0, ref_i = 1'b0;
    logic act_ok_o, rdwr_ok_o, pre_ok_o, cmd_err_o;
    int   checks = 0;
    int   failures = 0;

    TIMING_IF #(.CNT_W(8)) u_tif ();

    sal_bank_timer #(.CNT_W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .timing_if (u_tif),
        .act_i     (act_i),
        .rd_i      (rd_i),
        .wr_i      (wr_i),
        .pre_i     (pre_i),
        .ref_i     (ref_i),
        .act_ok_o  (act_ok_o),
        .rdwr_ok_o (rdwr_ok_o),
        .pre_ok_o  (pre_ok_o),
        .cmd_err_o (cmd_err_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic obs, input logic exp_v);
        checks++;
        assert (obs === exp_v) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp_v);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        act_i = 1'b0; rd_i = 1'b0; wr_i = 1'b0; pre_i = 1'b0; ref_i = 1'b0;
    endtask

    initial begin
        u_tif.t_rcd_m1 = 8'd3;  u_tif.t_ras_m1 = 8'd7;  u_tif.t_rc_m1  = 8'd10;
        u_tif.t_rp_m1  = 8'd2;  u_tif.t_rtp_m1 = 8'd2;  u_tif.t_wtp_m1 = 8'd5;
        u_tif.t_rfc_m1 = 8'd15;

        // Reset and idle
        act_i = 1'b1; rd_i = 1'b1;
        #2;
        chk("rst_act_ok", act_ok_o, 1'b1);
        chk("rst_rdwr_ok", rdwr_ok_o, 1'b1);
        chk("rst_pre_ok", pre_ok_o, 1'b1);
        chk("rst_cmd_err", cmd_err_o, 1'b0);
        @(posedge clk);
        #1;
        chk("rst_ignores_cmds", rdwr_ok_o, 1'b1);
        act_i = 1'b0; rd_i = 1'b0;
        rst_n = 1'b1;
        step();
        chk("idle_act_ok", act_ok_o, 1'b1);
        chk("idle_cmd_err", cmd_err_o, 1'b0);

        // ACT: tRCD=4, tRAS=8, tRC=11
        act_i = 1'b1;
        step();
        for (int k = 1; k <= 11; k++) begin
            chk($sformatf("act_rdwr_ok_c%0d", k), rdwr_ok_o, logic'(k >= 4));
            chk($sformatf("act_pre_ok_c%0d", k), pre_ok_o, logic'(k >= 8));
            chk($sformatf("act_act_ok_c%0d", k), act_ok_o, logic'(k >= 11));
            step();
        end

        // RD at 0 (tRTP=3), WR at 2 (tWTP=6)
        for (int k = 0; k <= 8; k++) begin
            rd_i = (k == 0);
            wr_i = (k == 2);
            chk($sformatf("rdwr_pre_ok_c%0d", k), pre_ok_o, logic'(k == 0 || k >= 8));
            step();
        end

        // Back-to-back RD restarts tRTP
        for (int k = 0; k <= 4; k++) begin
            rd_i = (k <= 1);
            chk($sformatf("rdrd_pre_ok_c%0d", k), pre_ok_o, logic'(k == 0 || k >= 4));
            step();
        end

        // PRE at 0 (tRP=3), REF at 3 (tRFC=16); field change mid-countdown has no effect
        for (int k = 0; k <= 19; k++) begin
            pre_i = (k == 0);
            ref_i = (k == 3);
            if (k == 7) u_tif.t_rfc_m1 = 8'd3;
            chk($sformatf("preref_act_ok_c%0d", k), act_ok_o, logic'(k == 0 || k == 3 || k >= 19));
            step();
        end

        // Early RD after ACT
        for (int k = 0; k <= 5; k++) begin
            act_i = (k == 0);
            rd_i  = (k == 2);
            chk($sformatf("early_cmd_err_c%0d", k), cmd_err_o, logic'(k == 3) & CHK);
            chk($sformatf("early_rdwr_ok_c%0d", k), rdwr_ok_o, logic'(k == 0 || k >= 4));
            step();
        end

        // ACT and RD in the same cycle
        for (int k = 0; k <= 2; k++) begin
            act_i = (k == 0);
            rd_i  = (k == 0);
            chk($sformatf("multi_cmd_err_c%0d", k), cmd_err_o, logic'(k == 1) & CHK);
            step();
        end

        // tRCD=1: loading 0 never drops the flag
        repeat (12) step();
        u_tif.t_rcd_m1 = 8'd0;
        chk("t1_rdwr_ok_c0", rdwr_ok_o, 1'b1);
        act_i = 1'b1;
        step();
        chk("t1_rdwr_ok_c1", rdwr_ok_o, 1'b1);
        chk("t1_act_ok_c1", act_ok_o, 1'b0);
        step();
        chk("t1_rdwr_ok_c2", rdwr_ok_o, 1'b1);

        // Asynchronous reset mid-countdown
        u_tif.t_rcd_m1 = 8'd3;
        repeat (12) step();
        act_i = 1'b1; pre_i = 1'b1;
        step();
        chk("mid_rdwr_ok_before", rdwr_ok_o, 1'b0);
        chk("mid_cmd_err_before", cmd_err_o, CHK);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_act_ok", act_ok_o, 1'b1);
        chk("mid_rst_rdwr_ok", rdwr_ok_o, 1'b1);
        chk("mid_rst_pre_ok", pre_ok_o, 1'b1);
        chk("mid_rst_cmd_err", cmd_err_o, 1'b0);
        step();
        rst_n = 1'b1;
        step();
        chk("post_rst_rdwr_ok", rdwr_ok_o, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
